// File: rtl/rotating_register_file_if.sv
// rotating_register_file_if: write/read/rotate bus between the context controller and the register file
interface rotating_register_file_if #(
    parameter int LOG2REGS = 3,
    parameter int SIZE     = 32,
    parameter int NUM_WR   = 4,
    parameter int NUM_RD   = 8
);
    logic                       rotate;
    logic [NUM_WR-1:0]          WE;
    logic [NUM_WR*LOG2REGS-1:0] address_in;
    logic [NUM_WR*SIZE-1:0]     in;
    logic [NUM_RD-1:0]          RE;
    logic [NUM_RD*LOG2REGS-1:0] address_out;
    logic [NUM_RD*SIZE-1:0]     out;
    logic [LOG2REGS-1:0]        base;
    logic                       wr_conflict;

    modport master (
        output rotate, WE, address_in, in, RE, address_out,
        input  out, base, wr_conflict
    );

    modport slave (
        input  rotate, WE, address_in, in, RE, address_out,
        output out, base, wr_conflict
    );
endinterface

// File: rtl/rotating_register_file.sv
// rotating_register_file: multi-port register file with rotating base, read enables and write-conflict flag
// Optional build macro RF_WRITE_BYPASS_EN forwards same-cycle write data to reads of the same register.
module rotating_register_file #(
    parameter int LOG2REGS = 3,
    parameter int SIZE     = 32,
    parameter int NUM_WR   = 4,
    parameter int NUM_RD   = 8
) (
    input logic CGRA_Clock,
    input logic CGRA_Reset_n,
    rotating_register_file_if.slave bus
);
    localparam int DEPTH = 2 ** LOG2REGS;

    logic [SIZE-1:0]     regs [DEPTH];
    logic [LOG2REGS-1:0] base_q;
    logic [LOG2REGS-1:0] wa [NUM_WR];
    logic [LOG2REGS-1:0] ra [NUM_RD];
    logic [SIZE-1:0]     wd [NUM_WR];
    logic [SIZE-1:0]     rd [NUM_RD];
    logic                conflict;

    assign bus.base = base_q;

    // Translate logical addresses to physical ones using the base from before this cycle's rotate
    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            wa[k] = bus.address_in[k*LOG2REGS +: LOG2REGS] + base_q;
            wd[k] = bus.in[k*SIZE +: SIZE];
        end
        for (int j = 0; j < NUM_RD; j++)
            ra[j] = bus.address_out[j*LOG2REGS +: LOG2REGS] + base_q;
    end

    // Any pair of enabled write ports hitting one physical register is a collision
    always_comb begin
        conflict = 1'b0;
        for (int k = 0; k < NUM_WR; k++)
            for (int m = k + 1; m < NUM_WR; m++)
                if (bus.WE[k] && bus.WE[m] && wa[k] == wa[m])
                    conflict = 1'b1;
    end

    // Select read data; with bypass the highest-numbered matching writer overrides the stored value
    always_comb begin
        for (int j = 0; j < NUM_RD; j++) begin
            rd[j] = regs[ra[j]];
`ifdef RF_WRITE_BYPASS_EN
            for (int k = 0; k < NUM_WR; k++)
                if (bus.WE[k] && wa[k] == ra[j])
                    rd[j] = wd[k];
`endif
        end
    end

    // Commit writes in ascending port order so the highest-numbered port's assignment lands last
    always_ff @(posedge CGRA_Clock or negedge CGRA_Reset_n) begin
        if (!CGRA_Reset_n) begin
            for (int p = 0; p < DEPTH; p++)
                regs[p] <= '0;
        end else begin
            for (int k = 0; k < NUM_WR; k++)
                if (bus.WE[k])
                    regs[wa[k]] <= wd[k];
        end
    end

    // Register read ports, advance the rotation base downward and register the conflict pulse
    always_ff @(posedge CGRA_Clock or negedge CGRA_Reset_n) begin
        if (!CGRA_Reset_n) begin
            bus.out         <= '0;
            base_q          <= '0;
            bus.wr_conflict <= 1'b0;
        end else begin
            for (int j = 0; j < NUM_RD; j++)
                if (bus.RE[j])
                    bus.out[j*SIZE +: SIZE] <= rd[j];
            if (bus.rotate)
                base_q <= base_q - LOG2REGS'(1);
            bus.wr_conflict <= conflict;
        end
    end
endmodule

// File: tb/tb_rotating_register_file.sv
// tb_rotating_register_file: directed checks of the default and a reshaped register file
module tb_rotating_register_file;
`ifdef RF_WRITE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    rotating_register_file_if #(3, 32, 4, 8) a ();
    rotating_register_file_if #(4, 16, 2, 3) b ();

    rotating_register_file #(.LOG2REGS(3), .SIZE(32), .NUM_WR(4), .NUM_RD(8)) dut_a (
        .CGRA_Clock(clk), .CGRA_Reset_n(rst_n), .bus(a.slave)
    );
    rotating_register_file #(.LOG2REGS(4), .SIZE(16), .NUM_WR(2), .NUM_RD(3)) dut_b (
        .CGRA_Clock(clk), .CGRA_Reset_n(rst_n), .bus(b.slave)
    );

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, o, e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a.rotate = 1'b0; a.WE = '0; a.RE = '0;
        a.address_in = '0; a.in = '0; a.address_out = '0;
        b.rotate = 1'b0; b.WE = '0; b.RE = '0;
        b.address_in = '0; b.in = '0; b.address_out = '0;
    endtask

    task automatic wr(input int k, input logic [2:0] addr, input logic [31:0] data);
        a.WE[k] = 1'b1;
        a.address_in[k*3 +: 3] = addr;
        a.in[k*32 +: 32] = data;
    endtask

    task automatic rd(input int j, input logic [2:0] addr);
        a.RE[j] = 1'b1;
        a.address_out[j*3 +: 3] = addr;
    endtask

    function automatic logic [63:0] oa(input int j);
        return 64'(a.out[j*32 +: 32]);
    endfunction

    int ord [16] = '{9, 2, 14, 5, 0, 11, 7, 15, 3, 12, 1, 8, 13, 6, 10, 4};

    initial begin
        idle();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_base", 64'(a.base), 64'd0);
        chk("rst_conflict", 64'(a.wr_conflict), 64'd0);
        chk("rst_out_zero", 64'(a.out == '0), 64'd1);
        tick();
        rst_n = 1'b1;

        // basic write then read on another port
        idle(); wr(0, 3'd3, 32'hDEADBEEF); tick();
        idle(); rd(5, 3'd3); tick();
        chk("basic_out5", oa(5), 64'hDEADBEEF);
        chk("basic_noconf", 64'(a.wr_conflict), 64'd0);

        // write collision: port 3 wins, one-cycle flag
        idle(); wr(0, 3'd2, 32'h11); wr(3, 3'd2, 32'h33); tick();
        chk("conf_pulse", 64'(a.wr_conflict), 64'd1);
        idle(); rd(0, 3'd2); tick();
        chk("conf_clear", 64'(a.wr_conflict), 64'd0);
        chk("conf_winner", oa(0), 64'h33);

        // rotation
        idle(); wr(1, 3'd7, 32'hA5); tick();
        idle(); a.rotate = 1'b1; tick();
        chk("rot_base7", 64'(a.base), 64'd7);
        idle(); rd(1, 3'd0); tick();
        chk("rot_read", oa(1), 64'hA5);
        idle(); a.rotate = 1'b1; repeat (8) tick();
        chk("rot_wrap8", 64'(a.base), 64'd7);
        repeat (7) tick();
        chk("rot_base0", 64'(a.base), 64'd0);

        // rotate + write + read in one cycle use the old base
        idle(); a.rotate = 1'b1; wr(0, 3'd1, 32'h55); rd(2, 3'd1); tick();
        chk("rwr_base", 64'(a.base), 64'd7);
        chk("rwr_rbw", oa(2), BYP ? 64'h55 : 64'h0);
        idle(); rd(2, 3'd2); tick();
        chk("rwr_moved", oa(2), 64'h55);

        // read during write to physical 4 (logical 5 at base 7)
        idle(); wr(0, 3'd5, 32'h10); tick();
        idle(); wr(0, 3'd5, 32'h20); rd(6, 3'd5); tick();
        chk("rdw_out", oa(6), BYP ? 64'h20 : 64'h10);
        idle(); tick();
        chk("rdw_hold", oa(6), BYP ? 64'h20 : 64'h10);
        chk("hold_out5", oa(5), 64'hDEADBEEF);
        idle(); rd(6, 3'd5); tick();
        chk("rdw_after", oa(6), 64'h20);

        // collision combined with a same-cycle read
        idle(); wr(1, 3'd6, 32'h61); wr(2, 3'd6, 32'h62); rd(7, 3'd6); tick();
        chk("byp_conf_out", oa(7), BYP ? 64'h62 : 64'h0);
        chk("byp_conf_flag", 64'(a.wr_conflict), 64'd1);
        idle(); rd(7, 3'd6); tick();
        chk("byp_conf_reg", oa(7), 64'h62);
        chk("byp_conf_clear", 64'(a.wr_conflict), 64'd0);

        // asynchronous reset mid-cycle
        idle(); a.rotate = 1'b1; wr(0, 3'd0, 32'hFFFF);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_base", 64'(a.base), 64'd0);
        chk("arst_out_zero", 64'(a.out == '0), 64'd1);
        chk("arst_conflict", 64'(a.wr_conflict), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(); rd(0, 3'd3); rd(1, 3'd6); rd(2, 3'd7); tick();
        chk("arst_reg3", oa(0), 64'h0);
        chk("arst_reg6", oa(1), 64'h0);
        chk("arst_reg7", oa(2), 64'h0);
        chk("arst_base_hold", 64'(a.base), 64'd0);

        // reshaped instance: fill with index pattern, read back shuffled
        for (int i = 0; i < 16; i += 2) begin
            idle();
            b.WE = 2'b11;
            b.address_in = {4'(i + 1), 4'(i)};
            b.in = {16'(i + 1) * 16'h1001, 16'(i) * 16'h1001};
            tick();
        end
        for (int n = 0; n < 16; n++) begin
            idle();
            b.RE[n % 3] = 1'b1;
            b.address_out[(n % 3)*4 +: 4] = 4'(ord[n]);
            tick();
            chk($sformatf("param_rd%0d", ord[n]), 64'(b.out[(n % 3)*16 +: 16]), 64'(16'(ord[n]) * 16'h1001));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
